// File: rtl/int_seq_ctrl.sv
// int_seq_ctrl: 8051 interrupt entry/exit sequencer.
// Accepts a request at an instruction boundary, acks the encoder,
// performs the hardware LCALL (push PCL, push PCH, jump to vector)
// while stalling fetch, and pulses RTI when RETI retires.
//
// Ports:
//   CPUClock, RESET_N       clock, async active-low reset
//   INT_REQ, VECTOR         encoder request and vector index
//   INSTR_END, BLOCK        instruction retire / entry inhibit
//   RETI_EXEC               retiring instruction is RETI
//   PC, SP                  return address, current stack pointer
//   STALL, BUSY             fetch hold, sequencer not idle
//   MEM_WE/ADDR/WDATA       internal RAM push port
//   SP_LD, SP_NEXT          stack pointer update
//   PC_LD, PC_NEXT          vector jump
//   IACK, RTI               one-cycle pulses to the encoder
//   NEST_ERR                sticky nesting error (optional)
//
// Optional feature: define INT_SEQ_NEST_CHK_EN to add a nesting
// depth counter and the NEST_ERR output.

module int_seq_ctrl #(
    parameter logic [15:0] VEC_BASE   = 16'h0003,
    parameter int          VEC_STRIDE = 8
) (
    input  logic        CPUClock,
    input  logic        RESET_N,
    input  logic        INT_REQ,
    input  logic [2:0]  VECTOR,
    input  logic        INSTR_END,
    input  logic        BLOCK,
    input  logic        RETI_EXEC,
    input  logic [15:0] PC,
    input  logic [7:0]  SP,
    output logic        STALL,
    output logic        MEM_WE,
    output logic [7:0]  MEM_ADDR,
    output logic [7:0]  MEM_WDATA,
    output logic        SP_LD,
    output logic [7:0]  SP_NEXT,
    output logic        PC_LD,
    output logic [15:0] PC_NEXT,
    output logic        IACK,
    output logic        RTI,
`ifdef INT_SEQ_NEST_CHK_EN
    output logic        NEST_ERR,
`endif
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_PUSH_L,
        S_PUSH_H,
        S_JUMP
    } state_t;

    state_t      state_q, state_d;
    logic        accept;
    logic        rti_req;
    logic        rti_d;

    logic [2:0]  vec_q;
    logic [15:0] pc_q;
    logic [7:0]  sp_q;

    logic        stall_d;
    logic        mem_we_d;
    logic [7:0]  mem_addr_d;
    logic [7:0]  mem_wdata_d;
    logic        sp_ld_d;
    logic [7:0]  sp_next_d;
    logic        pc_ld_d;
    logic [15:0] pc_next_d;
    logic        iack_d;

    logic [7:0]  sp_p1;
    logic [7:0]  sp_p2;
    logic [15:0] vec_addr;

    // Stack wraps modulo 256 with no overflow indication.
    assign sp_p1    = sp_q + 8'd1;
    assign sp_p2    = sp_q + 8'd2;
    assign vec_addr = VEC_BASE + (16'(vec_q) * 16'(VEC_STRIDE));

    assign rti_req  = INSTR_END & RETI_EXEC;

    // Next-state logic. Requests seen while busy are dropped; the
    // encoder keeps the level asserted until it is acknowledged.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (INSTR_END && INT_REQ && !BLOCK) begin
                    accept  = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK:    state_d = S_PUSH_L;
            S_PUSH_L: state_d = S_PUSH_H;
            S_PUSH_H: state_d = S_JUMP;
            S_JUMP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that they appear
    // registered in the same cycle as the state they belong to.
    always_comb begin
        stall_d     = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = 8'h00;
        mem_wdata_d = 8'h00;
        sp_ld_d     = 1'b0;
        sp_next_d   = 8'h00;
        pc_ld_d     = 1'b0;
        pc_next_d   = 16'h0000;
        iack_d      = 1'b0;
        unique case (state_d)
            S_IDLE: begin
            end
            S_ACK: begin
                stall_d = 1'b1;
                iack_d  = 1'b1;
            end
            S_PUSH_L: begin
                stall_d     = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = sp_p1;
                mem_wdata_d = pc_q[7:0];
            end
            S_PUSH_H: begin
                stall_d     = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = sp_p2;
                mem_wdata_d = pc_q[15:8];
                sp_ld_d     = 1'b1;
                sp_next_d   = sp_p2;
            end
            S_JUMP: begin
                stall_d   = 1'b1;
                pc_ld_d   = 1'b1;
                pc_next_d = vec_addr;
            end
            default: begin
            end
        endcase
    end

`ifdef INT_SEQ_NEST_CHK_EN
    logic [1:0] nest_q, nest_d;
    logic       nest_err_d;

    // Depth counter: +1 on entry (saturating at 2), -1 per RTI.
    // An RETI with nothing outstanding is swallowed and flagged.
    always_comb begin
        rti_d      = rti_req && (nest_q != 2'd0);
        nest_err_d = NEST_ERR;
        nest_d     = nest_q;
        if (rti_req && (nest_q == 2'd0))
            nest_err_d = 1'b1;
        if (accept && (nest_q == 2'd2))
            nest_err_d = 1'b1;
        if (accept && !rti_d) begin
            if (nest_q != 2'd2)
                nest_d = nest_q + 2'd1;
        end else if (rti_d && !accept) begin
            nest_d = nest_q - 2'd1;
        end
    end

    always_ff @(posedge CPUClock or negedge RESET_N) begin
        if (!RESET_N) begin
            nest_q   <= 2'd0;
            NEST_ERR <= 1'b0;
        end else begin
            nest_q   <= nest_d;
            NEST_ERR <= nest_err_d;
        end
    end
`else
    always_comb begin
        rti_d = rti_req;
    end
`endif

    always_ff @(posedge CPUClock or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            vec_q     <= 3'd0;
            pc_q      <= 16'h0000;
            sp_q      <= 8'h00;
            STALL     <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= 8'h00;
            MEM_WDATA <= 8'h00;
            SP_LD     <= 1'b0;
            SP_NEXT   <= 8'h00;
            PC_LD     <= 1'b0;
            PC_NEXT   <= 16'h0000;
            IACK      <= 1'b0;
            RTI       <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state_q <= state_d;
            // The encoder drops VECTOR while IACK is high, so the
            // request context is captured on the accepting edge.
            if (accept) begin
                vec_q <= VECTOR;
                pc_q  <= PC;
                sp_q  <= SP;
            end
            STALL     <= stall_d;
            MEM_WE    <= mem_we_d;
            MEM_ADDR  <= mem_addr_d;
            MEM_WDATA <= mem_wdata_d;
            SP_LD     <= sp_ld_d;
            SP_NEXT   <= sp_next_d;
            PC_LD     <= pc_ld_d;
            PC_NEXT   <= pc_next_d;
            IACK      <= iack_d;
            RTI       <= rti_d;
            BUSY      <= (state_d != S_IDLE);
        end
    end

endmodule

// File: doc/int_seq_ctrl.md
Name: int_seq_ctrl

Overview:
- Interrupt entry/exit sequencer for the 8051 core; sits between the priority encoder (INT_REQ/VECTOR/IACK/RTI) and the CPU fetch/stack datapath.
- At an instruction boundary it accepts a pending request, acknowledges the encoder, performs the hardware LCALL (push PC low, push PC high, load vector address) while stalling fetch, and signals RTI when RETI retires.

Parameters:
- VEC_BASE, 16'h0003, address of vector 0.
- VEC_STRIDE, 8, byte spacing between vectors; power of two, at most 128.

Ports:
- CPUClock  in  1  core clock, all state on rising edge
- RESET_N  in  1  asynchronous active-low reset
- INT_REQ  in  1  encoder request (combinational)
- VECTOR  in  3  encoder vector index
- INSTR_END  in  1  current instruction retires this cycle
- BLOCK  in  1  retiring instruction inhibits interrupt entry (RETI, IE/IP write)
- RETI_EXEC  in  1  retiring instruction is RETI (qualified by INSTR_END)
- PC  in  16  return address (address of next instruction)
- SP  in  8  current stack pointer
- STALL  out  1  hold fetch/decode
- MEM_WE  out  1  internal RAM write strobe
- MEM_ADDR  out  8  internal RAM address
- MEM_WDATA  out  8  internal RAM write data
- SP_LD  out  1  load SP_NEXT into SP
- SP_NEXT  out  8  new stack pointer
- PC_LD  out  1  load PC_NEXT into PC
- PC_NEXT  out  16  vector address
- IACK  out  1  one-cycle acknowledge to encoder
- RTI  out  1  one-cycle return-from-interrupt to encoder
- BUSY  out  1  state is not IDLE

Behaviour:
- States: IDLE, ACK, PUSH_L, PUSH_H, JUMP. All outputs are registered. Reset value of every output is 0 and state is IDLE.
- IDLE to ACK when INSTR_END & INT_REQ & ~BLOCK. In that same edge, latch VECTOR into vec_q, PC into pc_q and SP into sp_q. Latching here is required because the encoder drops INT_REQ/VECTOR while IACK is high.
- ACK: IACK=1 and STALL=1 for exactly one cycle, then go to PUSH_L.
- PUSH_L: MEM_WE=1, MEM_ADDR=sp_q+1, MEM_WDATA=pc_q[7:0], STALL=1. Then go to PUSH_H.
- PUSH_H: MEM_WE=1, MEM_ADDR=sp_q+2, MEM_WDATA=pc_q[15:8], SP_LD=1, SP_NEXT=sp_q+2, STALL=1. Then go to JUMP.
- JUMP: PC_LD=1, PC_NEXT=VEC_BASE+vec_q*VEC_STRIDE (16-bit, vec 7 allowed), STALL=1. Then go to IDLE.
- Entry latency: INSTR_END edge to PC_LD is 4 cycles. STALL is high exactly 4 cycles.
- SP arithmetic is modulo 256: sp_q=8'hFF gives addresses 8'h00 and 8'h01 and SP_NEXT=8'h01. No overflow flag.
- RTI: when INSTR_END & RETI_EXEC, RTI=1 for the next cycle only, in any state. RETI_EXEC without INSTR_END is ignored.
- Simultaneous RETI retirement and INT_REQ: BLOCK is asserted by the core on RETI, so entry is refused that cycle. RTI is still pulsed. Entry may occur at the following INSTR_END.
- INSTR_END/INT_REQ while BUSY: ignored. No queueing; the encoder holds the request level.
- INT_REQ dropping after acceptance: the sequence completes with the latched vector.
- Reset mid-sequence: immediate return to IDLE, all strobes deasserted asynchronously. A partial push is not undone.
- MEM_ADDR/MEM_WDATA/SP_NEXT/PC_NEXT are 0 whenever their strobe is low.

Optional Feature:
- Macro INT_SEQ_NEST_CHK_EN adds a 2-bit nesting counter and an output NEST_ERR (1 bit, sticky, cleared only by reset).
- Counter behaviour: increments at ACK and saturates at 2. Decrements when RTI is issued.
- RTI with counter=0: RTI is suppressed and NEST_ERR is set.
- Entry while counter=2: NEST_ERR is set; the sequence still proceeds.
- Without the macro: no counter, no NEST_ERR port, and RTI is unconditional.

Test Plan:
- SP=8'h07, PC=16'h1234, VECTOR=3'd1, INT_REQ with INSTR_END -> IACK at cycle+1; writes [08]=34 and [09]=12; SP_NEXT=8'h09; PC_NEXT=16'h000B at cycle+4; STALL high 4 cycles.
- VECTOR=3'd6 -> PC_NEXT=16'h0033. Rerun with VEC_STRIDE=16 and VECTOR=3'd7 -> PC_NEXT=16'h0073.
- SP=8'hFF, PC=16'hABCD -> writes [00]=CD and [01]=AB; SP_NEXT=8'h01.
- INSTR_END with RETI_EXEC=1, BLOCK=1, INT_REQ=1 -> RTI one cycle, no IACK. Next INSTR_END with BLOCK=0 -> normal entry.
- Assert RESET_N=0 during PUSH_H -> MEM_WE/SP_LD drop immediately; no PC_LD follows; after release, BUSY=0.
- With INT_SEQ_NEST_CHK_EN: RETI_EXEC&INSTR_END after reset -> no RTI, NEST_ERR=1. One entry followed by RETI -> RTI pulses, NEST_ERR stays as set.
